// File: rtl/datamemory_pipe.sv
// Purpose : single-port word-addressed data memory with byte enables and a pipelined read path.
// Latency : read data appears RD_LATENCY cycles after acceptance (visible right after the acceptance edge when RD_LATENCY=1).
// Backpres: req_ready drops during reset (and during the clear sequence); responses cannot be stalled.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake; req_we selects write (1) or read (0)
//   req_addr/req_wdata/req_be- word address, write data, per-byte write enables
//   rsp_valid/rsp_rdata      - one-cycle read response pulse; rdata holds between pulses
//   busy                     - clear sequence in progress
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN (zero the whole array after every reset).

module datamemory_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [RD_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0] r_dat [RD_LATENCY];

  logic w_acc;
  logic w_wr;
  logic w_rd;

  assign w_acc = req_valid && req_ready;
  assign w_wr  = w_acc && req_we;
  assign w_rd  = w_acc && !req_we;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic                  w_clr;

  // Clear walks every address once; leaving CLEAR on the edge that writes
  // the last address makes req_ready rise on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
      if (r_clr_ptr == '1) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign w_clr     = !rst && (r_state == S_CLEAR);
  assign req_ready = !rst && (r_state == S_IDLE);
  assign busy      = rst || (r_state == S_CLEAR);
`else
  assign req_ready = !rst;
  assign busy      = 1'b0;
`endif

  // Array has no reset: contents persist unless the clear sequencer runs.
  // Clear writes and request writes never coincide because req_ready is low in CLEAR.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (w_clr) begin
      r_mem[r_clr_ptr] <= '0;
    end
`endif
    if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline: data stages only advance behind a valid bit, so the last
  // stage (and rsp_rdata) keeps the most recent response between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) begin
        r_dat[0] <= r_mem[req_addr];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign rsp_valid = r_vld[RD_LATENCY-1];
  assign rsp_rdata = r_dat[RD_LATENCY-1];

endmodule

// File: tb/tb_datamemory_pipe.sv
// Purpose : randomized + directed bench for datamemory_pipe against a behavioural memory model.
// Latency : model schedules each read response RD_LATENCY-1 edges after its acceptance edge.
// Backpres: model predicts req_ready/busy itself and only accepts when it expects readiness.

module tb_datamemory_pipe;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int RL    = 3;
  localparam int DEPTH = 1 << AW;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  always #5 clk = ~clk;

  datamemory_pipe #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  rsp_t          exp_q [$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last_d;
  int            clr_left;
  int            cyc;
  int            checks;
  int            errs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own view of readiness.
  task automatic step(input logic r, input logic v, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    logic acc;
    logic ev;
    rst       = r;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    acc = v && !r && (clr_left == 0);
    @(posedge clk);
    cyc++;
    if (r) begin
      exp_q.delete();
      last_d = '0;
      if (BUSY_EN) begin
        clr_left = DEPTH;
        foreach (mem_m[i]) mem_m[i] = '0;
      end
    end else begin
      if (clr_left > 0) clr_left--;
      if (acc && we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
        end
      end else if (acc) begin
        exp_q.push_back('{mem_m[a], cyc + RL - 1});
      end
    end
    #1;
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      last_d = exp_q[0].d;
      void'(exp_q.pop_front());
    end
    chk("rsp_rdata", rsp_rdata, last_d);
    chk("req_ready", 32'(req_ready), 32'(!r && (clr_left == 0)));
    chk("busy", 32'(busy), 32'(BUSY_EN && (r || (clr_left > 0))));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    step(1'b0, 1'b1, 1'b1, a, d, be);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0);
  endtask

  task automatic wait_clear();
    for (int n = 0; n < 4 * DEPTH && clr_left > 0; n++) idle(1);
  endtask

  initial begin
    logic          rr;
    logic          rv;
    logic          rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_v;
    logic [3:0]    rb;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    clr_left = BUSY_EN ? DEPTH : 0;
    cyc = 0; checks = 0; errs = 0; last_d = '0;
    foreach (mem_m[i]) mem_m[i] = '0;

    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    wait_clear();

    // Give every word a known value so reads never depend on power-up contents.
    for (int i = 0; i < DEPTH; i++) wr(i[AW-1:0], $urandom, 4'hF);

    // Byte-enable merge
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd5, 32'hAABBCCDD, 4'h5);
    rd(4'd5);
    idle(4);
    chk("be_merge", rsp_rdata, 32'h11BB33DD);

    // Back-to-back reads, addresses 0..3
    for (int i = 0; i < 4; i++) rd(i[AW-1:0]);
    idle(5);

    // Read-after-write and write-after-read
    wr(4'd7, 32'h5, 4'hF);
    rd(4'd7);
    idle(4);
    chk("raw", rsp_rdata, 32'h5);
    rd(4'd7);
    wr(4'd7, 32'h9, 4'hF);
    idle(4);
    chk("war", rsp_rdata, 32'h5);
    rd(4'd7);
    idle(4);
    chk("war_after", rsp_rdata, 32'h9);

    // Zero byte enables leave the word untouched
    wr(4'd7, 32'hFFFFFFFF, 4'h0);
    rd(4'd7);
    idle(4);
    chk("be_zero", rsp_rdata, 32'h9);

    // Reset with a read in flight, then a second reset part-way through any clear
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    rd(4'd3);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    wait_clear();
    rd(4'd3);
    idle(4);
    chk("post_reset_rd", rsp_rdata, BUSY_EN ? 32'h0 : 32'hDEADBEEF);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rr   = ($urandom_range(0, 79) == 0);
      rv   = ($urandom_range(0, 3) != 0);
      rw   = ($urandom_range(0, 1) == 1);
      ra   = AW'($urandom_range(0, DEPTH - 1));
      rd_v = $urandom;
      rb   = 4'($urandom_range(0, 15));
      step(rr, rv, rw, ra, rd_v, rb);
    end
    idle(RL + 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
